// File: rtl/rr_arb_pkg.sv
// Shared types and sizing helpers for the N-way round-robin arbiter.
// rr_pick is a loop-based behavioural picker; the synthesised path uses rr_pick_comb.
package rr_arb_pkg;

    localparam int MAX_REQ = 32;

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    function automatic int idx_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Counter only needs to reach MAX_HOLD-1; keep at least one bit for MAX_HOLD of 0..2.
    function automatic int cnt_w(input int max_hold);
        return (max_hold > 2) ? $clog2(max_hold) : 1;
    endfunction

    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] vec,
                                      input logic [4:0] last_id,
                                      input int n_req = MAX_REQ);
        pick_t r;
        int    c;
        r = '0;
        for (int k = 1; k <= n_req; k++) begin
            c = (int'(last_id) + k) % n_req;
            if (!r.found && vec[c]) begin
                r.found = 1'b1;
                r.idx   = 5'(c);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface rr_arbiter_n_if #(
    parameter int N_REQ = 4
);
    localparam int IDX_W = rr_arb_pkg::idx_w(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_id;
    logic             gnt_vld;

    modport master (output req, input gnt, input gnt_id, input gnt_vld);
    modport slave  (input req, output gnt, output gnt_id, output gnt_vld);
endinterface

// File: rtl/rr_pick_comb.sv
// Circular priority picker: first set bit of vec_i searching from last_id_i+1 around to last_id_i.
module rr_pick_comb
    import rr_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] vec_i,
    input  logic [IDX_W-1:0] last_id_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);
    logic [N_REQ:0]     lo_mask;
    logic [2*N_REQ-1:0] dbl;
    logic [IDX_W:0]     pos;

    // Lower half holds only bits above last_id; the upper half is the wrapped, unmasked copy.
    assign lo_mask = ((N_REQ+1)'(1) << (int'(last_id_i) + 1)) - (N_REQ+1)'(1);
    assign dbl     = {vec_i, vec_i & ~lo_mask[N_REQ-1:0]};

    always_comb begin
        pos = '0;
        for (int i = 2*N_REQ-1; i >= 0; i--) begin
            if (dbl[i]) pos = (IDX_W+1)'(i);
        end
    end

    assign found_o = |vec_i;
    assign idx_o   = (pos >= (IDX_W+1)'(N_REQ)) ? IDX_W'(pos - (IDX_W+1)'(N_REQ))
                                                : IDX_W'(pos);
endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with grant hold and optional hold quantum; all outputs registered.
module rr_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDX_W    = idx_w(N_REQ),
    localparam int CNT_W    = cnt_w(MAX_HOLD)
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_n_if.slave bus
);
    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] last_id_q, last_id_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
    logic             gnt_vld_q, gnt_vld_d;

    logic [N_REQ-1:0] cand;
    logic             win_found;
    logic [IDX_W-1:0] win_id;
    logic             owner_req;
    logic             expired;

    // The owner bit is masked while OWNED: it is already 0 on release and must be skipped on expiry.
    assign cand      = (state_q == ST_OWNED) ? (bus.req & ~gnt_q) : bus.req;
    assign owner_req = |(bus.req & gnt_q);
    assign expired   = (MAX_HOLD > 0) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    rr_pick_comb #(.N_REQ(N_REQ)) u_pick (
        .vec_i     (cand),
        .last_id_i (last_id_q),
        .found_o   (win_found),
        .idx_o     (win_id)
    );

    always_comb begin
        // NOTE: every next-state value gets its hold default first so no path infers a latch.
        state_d    = state_q;
        last_id_d  = last_id_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        gnt_vld_d  = gnt_vld_q;

        if (state_q == ST_OWNED && owner_req && !expired) begin
            if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (win_found) begin
            state_d    = ST_OWNED;
            last_id_d  = win_id;
            hold_cnt_d = '0;
            gnt_d      = N_REQ'(1) << win_id;
            gnt_id_d   = win_id;
            gnt_vld_d  = 1'b1;
        end else if (state_q == ST_OWNED && owner_req) begin
            // Quantum expired with nobody else waiting: renew the same owner.
            last_id_d  = gnt_id_q;
            hold_cnt_d = '0;
        end else begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
            gnt_d      = '0;
            gnt_id_d   = '0;
            gnt_vld_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_id_q  <= IDX_W'(N_REQ - 1);
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            gnt_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_id_q  <= last_id_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_vld_q  <= gnt_vld_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.gnt_vld = gnt_vld_q;
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Self-checking bench: three 4-way arbiters (MAX_HOLD 8, 4, 0) share one request stream and a reference model.
module tb_rr_arbiter_n;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rr_arbiter_n_if #(.N_REQ(N)) bus8 ();
    rr_arbiter_n_if #(.N_REQ(N)) bus4 ();
    rr_arbiter_n_if #(.N_REQ(N)) bus0 ();

    rr_arbiter_n #(.N_REQ(N), .MAX_HOLD(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    rr_arbiter_n #(.N_REQ(N), .MAX_HOLD(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    rr_arbiter_n #(.N_REQ(N), .MAX_HOLD(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    // Reference model: owner (-1 = idle), last granted index, cycles held in the current grant.
    int mh    [3] = '{8, 4, 0};
    int owner [3];
    int last  [3];
    int held  [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int from_last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (from_last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_update(input logic r, input logic [N-1:0] rq);
        for (int i = 0; i < 3; i++) begin
            logic [N-1:0] others;
            int w;
            if (r) begin
                owner[i] = -1; last[i] = N - 1; held[i] = 0;
            end else if (owner[i] < 0) begin
                w = pick(rq, last[i]);
                if (w >= 0) begin owner[i] = w; last[i] = w; held[i] = 1; end
            end else if (rq[owner[i]] && !(mh[i] > 0 && held[i] == mh[i])) begin
                held[i]++;
            end else begin
                others = rq;
                others[owner[i]] = 1'b0;
                w = pick(others, last[i]);
                if (w >= 0) begin
                    owner[i] = w; last[i] = w; held[i] = 1;
                end else if (rq[owner[i]]) begin
                    last[i] = owner[i]; held[i] = 1;
                end else begin
                    owner[i] = -1; held[i] = 0;
                end
            end
        end
    endtask

    function automatic logic [N-1:0] dut_gnt(input int i);
        case (i)
            0: return bus8.gnt;
            1: return bus4.gnt;
            default: return bus0.gnt;
        endcase
    endfunction

    function automatic logic [1:0] dut_id(input int i);
        case (i)
            0: return bus8.gnt_id;
            1: return bus4.gnt_id;
            default: return bus0.gnt_id;
        endcase
    endfunction

    function automatic logic dut_vld(input int i);
        case (i)
            0: return bus8.gnt_vld;
            1: return bus4.gnt_vld;
            default: return bus0.gnt_vld;
        endcase
    endfunction

    // Apply one cycle of inputs, advance the model on the edge, compare all DUTs 1 time unit later.
    task automatic step(input logic r, input logic [N-1:0] rq);
        logic [N-1:0] eg;
        rst      = r;
        bus8.req = rq;
        bus4.req = rq;
        bus0.req = rq;
        @(posedge clk);
        model_update(r, rq);
        #1;
        for (int i = 0; i < 3; i++) begin
            eg = (owner[i] < 0) ? '0 : (N'(1) << owner[i]);
            check($sformatf("model_gnt_mh%0d", mh[i]), 32'(dut_gnt(i)), 32'(eg));
            check($sformatf("model_id_mh%0d", mh[i]), 32'(dut_id(i)),
                  32'((owner[i] < 0) ? 0 : owner[i]));
            check($sformatf("model_vld_mh%0d", mh[i]), 32'(dut_vld(i)), 32'(owner[i] >= 0));
        end
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [1:0]   id;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [N-1:0] rq;

        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0};
        tbl[1]  = '{1'b0, 4'b0001, 4'b0001, 2'd0};
        tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 2'd0};
        tbl[3]  = '{1'b0, 4'b0011, 4'b0010, 2'd1};  // last_id stayed 0 over idle, so 1 wins
        tbl[4]  = '{1'b0, 4'b1001, 4'b1000, 2'd3};  // owner 1 releases: 3 follows, no gap
        tbl[5]  = '{1'b0, 4'b1111, 4'b1000, 2'd3};
        tbl[6]  = '{1'b0, 4'b0111, 4'b0001, 2'd0};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 2'd0};
        tbl[8]  = '{1'b0, 4'b0100, 4'b0100, 2'd2};
        tbl[9]  = '{1'b1, 4'b0100, 4'b0000, 2'd0};  // reset mid-grant drops the owner
        tbl[10] = '{1'b0, 4'b1111, 4'b0001, 2'd0};

        bus8.req = '0; bus4.req = '0; bus0.req = '0;
        step(1'b1, 4'b0000);

        for (int t = 0; t < 11; t++) begin
            step(tbl[t].rst, tbl[t].req);
            check($sformatf("tbl%0d_gnt", t), 32'(bus8.gnt), 32'(tbl[t].gnt));
            check($sformatf("tbl%0d_id", t), 32'(bus8.gnt_id), 32'(tbl[t].id));
            check($sformatf("tbl%0d_vld", t), 32'(bus8.gnt_vld), 32'(tbl[t].gnt != 0));
        end

        // Full contention: owners 0,1,2,3,0 for exactly 8 cycles each.
        step(1'b1, 4'b0000);
        for (int c = 0; c < 40; c++) begin
            step(1'b0, 4'b1111);
            check($sformatf("rot%0d_id", c), 32'(bus8.gnt_id), 32'((c / 8) % 4));
            check($sformatf("rot%0d_vld", c), 32'(bus8.gnt_vld), 32'd1);
        end

        // Lone requester with MAX_HOLD=4: continuous grant, counter renews every 4 cycles.
        step(1'b1, 4'b0000);
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 4'b0100);
            check($sformatf("solo%0d_gnt", c), 32'(bus4.gnt), 32'h4);
            check($sformatf("solo%0d_cnt", c), 32'(u_dut4.hold_cnt_q), 32'(c % 4));
        end

        // Unlimited hold: master 0 keeps the grant while 3 waits, then 3 takes over on release.
        step(1'b1, 4'b0000);
        for (int c = 0; c < 50; c++) begin
            step(1'b0, 4'b1001);
            check($sformatf("hold%0d_gnt", c), 32'(bus0.gnt), 32'h1);
        end
        step(1'b0, 4'b1000);
        check("hold_handover_gnt", 32'(bus0.gnt), 32'h8);
        check("hold_handover_id", 32'(bus0.gnt_id), 32'd3);

        // Random traffic against the model; requests tend to persist so holds and expiries occur.
        rq = '0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) rq = N'($urandom_range(0, 15));
            step(($urandom_range(0, 99) == 0), rq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
